// File: rtl/aes_state_sel_ctrl.sv
// AES cipher-core state-register input mux sequencer.
// Walks one block through CLEAR / INIT / ROUND phases, drives a sparse mux3
// select through a buffering checker and latches a terminal alert on any
// corrupted select, state or round count.

package aes_pkg;

   // Sparse select codes for the 3-input state register mux.
   typedef enum logic [4:0] {
      MUX3_SEL_0 = 5'b01110,
      MUX3_SEL_1 = 5'b11000,
      MUX3_SEL_2 = 5'b00001
   } mux3_sel_e;

   // Sequencer states, pairwise Hamming distance >= 3 (codewords of a [6,3,3] code).
   typedef enum logic [5:0] {
      ST_IDLE  = 6'b100110,
      ST_INIT  = 6'b010101,
      ST_ROUND = 6'b001011,
      ST_DONE  = 6'b110011,
      ST_CLEAR = 6'b101101,
      ST_ERROR = 6'b011110
   } ctrl_state_e;

endpackage

// Select buffer and checker: passes the select through (optionally via a
// double-inverting buffer pair) and flags any value that is not a legal code.
module aes_sel_buf_chk #(
   parameter int unsigned Num      = 3,
   parameter int unsigned Width    = 5,
   parameter bit          EnSecBuf = 1'b0
) (
   input  logic [Width-1:0] sel_i,
   output logic [Width-1:0] sel_o,
   output logic             err_o
);
   import aes_pkg::*;

   if (EnSecBuf) begin : g_sec_buf
      logic [Width-1:0] sel_n;
      assign sel_n = ~sel_i;
      assign sel_o = ~sel_n;
   end else begin : g_plain
      assign sel_o = sel_i;
   end

   // The check is done on the buffered value so corruption of the buffer is caught too.
   always_comb begin
      err_o = 1'b1;
      if (sel_o == Width'(MUX3_SEL_0)) begin
         err_o = 1'b0;
      end
      if ((Num > 1) && (sel_o == Width'(MUX3_SEL_1))) begin
         err_o = 1'b0;
      end
      if ((Num > 2) && (sel_o == Width'(MUX3_SEL_2))) begin
         err_o = 1'b0;
      end
   end

endmodule

module aes_state_sel_ctrl #(
   parameter bit EnSecBuf = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [3:0] num_rounds_i,
   input  logic       clear_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic [4:0] state_sel_o,
   output logic       state_we_o,
   output logic [3:0] round_o,
   output logic       last_round_o,
   output logic       alert_o
);
   import aes_pkg::*;

   localparam logic [3:0] MaxRounds = 4'd14;

   ctrl_state_e state_q, state_d;
   logic [3:0]  n_q, n_d;
   logic [3:0]  cnt_q, cnt_d;
   mux3_sel_e   sel_dec;
   logic [4:0]  sel_raw;
   logic [4:0]  sel_buf;
   logic        sel_err;

   // Raw select as decoded from the state; only its buffered copy leaves the block.
   assign sel_raw = sel_dec;

   aes_sel_buf_chk #(
      .Num      (3),
      .Width    (5),
      .EnSecBuf (EnSecBuf)
   ) u_sel_buf_chk (
      .sel_i (sel_raw),
      .sel_o (sel_buf),
      .err_o (sel_err)
   );

   assign state_sel_o = sel_buf;

   // Output decode from registered state, round count and counter (plus clear_i for ready).
   always_comb begin
      sel_dec      = MUX3_SEL_0;
      in_ready_o   = 1'b0;
      out_valid_o  = 1'b0;
      state_we_o   = 1'b0;
      round_o      = cnt_q;
      last_round_o = 1'b0;
      alert_o      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready_o = ~clear_i;
         end
         ST_INIT: begin
            sel_dec    = MUX3_SEL_1;
            state_we_o = 1'b1;
            round_o    = '0;
         end
         ST_ROUND: begin
            sel_dec      = MUX3_SEL_2;
            state_we_o   = 1'b1;
            last_round_o = (cnt_q == n_q);
         end
         ST_DONE: begin
            sel_dec     = MUX3_SEL_2;
            out_valid_o = 1'b1;
            round_o     = n_q;
         end
         ST_CLEAR: begin
            state_we_o = 1'b1;
         end
         ST_ERROR: begin
            alert_o = 1'b1;
         end
         default: begin
            sel_dec = MUX3_SEL_0;
         end
      endcase
   end

   // Next-state logic; error conditions override everything, clear_i aborts a block.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clear_i) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end else if (in_valid_i) begin
               n_d   = num_rounds_i;
               cnt_d = '0;
               if ((num_rounds_i == '0) || (num_rounds_i > MaxRounds)) begin
                  state_d = ST_ERROR;
               end else begin
                  state_d = ST_INIT;
               end
            end
         end
         ST_INIT: begin
            state_d = ST_ROUND;
            cnt_d   = 4'd1;
         end
         ST_ROUND: begin
            if (cnt_q > n_q) begin
               state_d = ST_ERROR;
            end else if (cnt_q == n_q) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_DONE: begin
            if (out_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_ERROR;
         end
      endcase

      // Abort of an in-flight block; a detected round-count error still wins.
      if (clear_i && (state_d != ST_ERROR) &&
          ((state_q == ST_INIT) || (state_q == ST_ROUND) || (state_q == ST_DONE))) begin
         state_d = ST_CLEAR;
         cnt_d   = '0;
      end

      if (sel_err) begin
         state_d = ST_ERROR;
      end
   end

   // State, round count and counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
